// File: rtl/dwc_downsample_if.sv
// AXI-Stream style link used on both sides of the width converter.
// Ports (per modport):
//   master: drives tdata/tvalid, receives tready
//   slave : receives tdata/tvalid, drives tready
interface dwc_downsample_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/dwc_downsample.sv
// Narrowing stream width converter: one IN_WIDTH word in, TOTAL_ITERS
// OUT_WIDTH words out, least-significant slice first, one word per clock
// when both sides are ready.
// Ports:
//   ap_clk        clock, rising edge
//   ap_rst_n      synchronous active-low reset
//   s_axis_input  slave link, IN_WIDTH wide words in
//   m_axis_output master link, OUT_WIDTH wide slices out
module dwc_downsample #(
    parameter int unsigned IN_WIDTH         = 32,
    parameter int unsigned OUT_WIDTH        = 8,
    parameter int unsigned ACTIVATION_WIDTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    dwc_downsample_if.slave  s_axis_input,
    dwc_downsample_if.master m_axis_output
);

    localparam int unsigned TOTAL_ITERS = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W       = $clog2(TOTAL_ITERS + 1);

    // Parameter legality; a bad combination stops elaboration.
    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
        $fatal(1, "dwc_downsample: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (OUT_WIDTH % ACTIVATION_WIDTH != 0) begin : g_bad_act
        $fatal(1, "dwc_downsample: OUT_WIDTH must be a multiple of ACTIVATION_WIDTH");
    end
    if (TOTAL_ITERS < 1) begin : g_bad_iters
        $fatal(1, "dwc_downsample: IN_WIDTH/OUT_WIDTH must be at least 1");
    end

    logic [IN_WIDTH-1:0]  hold_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [OUT_WIDTH-1:0] slice;
    logic                 out_valid;
    logic                 in_ready;
    logic                 in_fire;
    logic                 out_fire;

    // Output is valid while slices of the held word remain.
    assign out_valid = (cnt_q != '0);

    // Ready when empty, or when the last slice leaves this cycle; the path
    // from m_axis_output.tready is deliberate so words stream without a gap.
    assign in_ready = ap_rst_n &&
                      ((cnt_q == '0) ||
                       ((cnt_q == CNT_W'(1)) && m_axis_output.tready));

    assign in_fire  = s_axis_input.tvalid && in_ready;
    assign out_fire = out_valid && m_axis_output.tready;

    // Remaining-slice counter; a new word has priority over a pending decrement.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else if (in_fire) begin
            cnt_q <= CNT_W'(TOTAL_ITERS);
        end else if (out_fire) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Holding register is data-only, so it carries no reset.
    always_ff @(posedge ap_clk) begin
        if (in_fire) begin
            hold_q <= s_axis_input.tdata;
        end
    end

    // Slice index is TOTAL_ITERS - cnt: cnt == TOTAL_ITERS selects slice 0.
    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < TOTAL_ITERS; i++) begin
            if (cnt_q == CNT_W'(TOTAL_ITERS - i)) begin
                slice = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign s_axis_input.tready  = in_ready;
    assign m_axis_output.tvalid = out_valid;
    assign m_axis_output.tdata  = slice;

endmodule

// File: tb/tb_dwc_downsample.sv
// Bench for dwc_downsample: a 32->8 instance (A) and a 16->16 instance (B).
// Directed sequences check exact cycle behaviour; per-instance monitors pop
// expected slices from scoreboards filled when a word is accepted.
module tb_dwc_downsample;

    logic clk = 1'b0;
    logic rst_n;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    dwc_downsample_if #(.WIDTH(32)) a_in  ();
    dwc_downsample_if #(.WIDTH(8))  a_out ();
    dwc_downsample_if #(.WIDTH(16)) b_in  ();
    dwc_downsample_if #(.WIDTH(16)) b_out ();

    dwc_downsample #(
        .IN_WIDTH        (32),
        .OUT_WIDTH       (8),
        .ACTIVATION_WIDTH(8)
    ) dut_a (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .s_axis_input (a_in),
        .m_axis_output(a_out)
    );

    dwc_downsample #(
        .IN_WIDTH        (16),
        .OUT_WIDTH       (16),
        .ACTIVATION_WIDTH(8)
    ) dut_b (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .s_axis_input (b_in),
        .m_axis_output(b_out)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a wide word becomes its bytes, low byte first.
    logic [7:0]  qa[$];
    logic [15:0] qb[$];
    bit          a_stall = 1'b0;
    bit          b_stall = 1'b0;
    logic [7:0]  a_last;
    logic [15:0] b_last;

    // Monitors sample mid-cycle: what they see is what the next edge commits.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            a_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check("a_hold_valid", a_out.tvalid, 1);
                check("a_hold_data", a_out.tdata, a_last);
            end
            if (qa.size() == 0) check("a_idle_valid", a_out.tvalid, 0);
            if (a_out.tvalid && a_out.tready && qa.size() != 0) begin
                check("a_sb_data", a_out.tdata, qa.pop_front());
            end
            if (a_in.tvalid && a_in.tready) begin
                for (int i = 0; i < 4; i++) qa.push_back(8'(a_in.tdata >> (8 * i)));
            end
            a_stall = a_out.tvalid && !a_out.tready;
            a_last  = a_out.tdata;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
            b_stall = 1'b0;
        end else begin
            if (b_stall) begin
                check("b_hold_valid", b_out.tvalid, 1);
                check("b_hold_data", b_out.tdata, b_last);
            end
            if (qb.size() == 0) check("b_idle_valid", b_out.tvalid, 0);
            if (b_out.tvalid && b_out.tready && qb.size() != 0) begin
                check("b_sb_data", b_out.tdata, qb.pop_front());
            end
            if (b_in.tvalid && b_in.tready) qb.push_back(b_in.tdata);
            b_stall = b_out.tvalid && !b_out.tready;
            b_last  = b_out.tdata;
        end
    end

    task automatic rand_a(input int unsigned words);
        int unsigned sent   = 0;
        int unsigned cycles = 0;
        bit          fired;
        while (sent < words && cycles < 40000) begin
            @(negedge clk);
            fired = a_in.tvalid && a_in.tready;
            @(posedge clk);
            #1;
            cycles++;
            if (fired) sent++;
            if (!a_in.tvalid || fired) begin
                if (sent < words && $urandom_range(3, 0) != 0) begin
                    a_in.tvalid = 1'b1;
                    a_in.tdata  = $urandom;
                end else begin
                    a_in.tvalid = 1'b0;
                end
            end
            a_out.tready = ($urandom_range(2, 0) != 0);
        end
        a_in.tvalid  = 1'b0;
        a_out.tready = 1'b1;
        check("a_rand_words", sent, words);
    endtask

    task automatic rand_b(input int unsigned words);
        int unsigned sent   = 0;
        int unsigned cycles = 0;
        bit          fired;
        while (sent < words && cycles < 20000) begin
            @(negedge clk);
            fired = b_in.tvalid && b_in.tready;
            @(posedge clk);
            #1;
            cycles++;
            if (fired) sent++;
            if (!b_in.tvalid || fired) begin
                if (sent < words && $urandom_range(3, 0) != 0) begin
                    b_in.tvalid = 1'b1;
                    b_in.tdata  = 16'($urandom);
                end else begin
                    b_in.tvalid = 1'b0;
                end
            end
            b_out.tready = ($urandom_range(2, 0) != 0);
        end
        b_in.tvalid  = 1'b0;
        b_out.tready = 1'b1;
        check("b_rand_words", sent, words);
    endtask

    // Accept one word on A at the next edge (A must be idle).
    task automatic send_a(input logic [31:0] w);
        @(posedge clk);
        #1;
        a_in.tdata  = w;
        a_in.tvalid = 1'b1;
        @(negedge clk);
        check("a_ready_idle", a_in.tready, 1);
        @(posedge clk);
        #1;
        a_in.tvalid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst_n        = 1'b0;
        a_in.tvalid  = 1'b0;
        a_in.tdata   = '0;
        a_out.tready = 1'b1;
        b_in.tvalid  = 1'b0;
        b_in.tdata   = '0;
        b_out.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", a_in.tready, 0);
        check("rst_a_valid", a_out.tvalid, 0);
        check("rst_b_ready", b_in.tready, 0);
        check("rst_b_valid", b_out.tvalid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_a_ready", a_in.tready, 1);
        check("post_rst_a_valid", a_out.tvalid, 0);

        // Single word, slices on consecutive cycles
        w = 32'hDDCCBBAA;
        send_a(w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", a_out.tvalid, 1);
            check("t1_data", a_out.tdata, 8'(w >> (8 * i)));
            check("t1_in_ready", a_in.tready, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        check("t1_idle", a_out.tvalid, 0);

        // Back-to-back words, no bubble
        @(posedge clk);
        #1;
        a_in.tdata  = 32'h44332211;
        a_in.tvalid = 1'b1;
        @(posedge clk);
        #1;
        a_in.tdata = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_valid", a_out.tvalid, 1);
            check("t2_data", a_out.tdata, 8'(8'h11 * (i + 1)));
            check("t2_in_ready", a_in.tready, (i % 4 == 3) ? 1 : 0);
            if (i == 3) begin
                @(posedge clk);
                #1;
                a_in.tvalid = 1'b0;
            end
        end
        @(negedge clk);
        check("t2_idle", a_out.tvalid, 0);

        // Backpressure while 0xBB is presented
        send_a(32'hDDCCBBAA);
        @(negedge clk);
        check("t3_first", a_out.tdata, 8'hAA);
        @(posedge clk);
        #1;
        a_out.tready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_valid", a_out.tvalid, 1);
            check("t3_stall_data", a_out.tdata, 8'hBB);
            check("t3_stall_in_ready", a_in.tready, 0);
        end
        @(posedge clk);
        #1;
        a_out.tready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("t3_resume_valid", a_out.tvalid, 1);
            check("t3_resume_data", a_out.tdata, 8'(8'hAA + 8'h11 * i));
        end
        @(negedge clk);
        check("t3_idle", a_out.tvalid, 0);

        // Reset with 0xCC pending
        send_a(32'hDDCCBBAA);
        @(negedge clk);
        check("t4_s0", a_out.tdata, 8'hAA);
        @(negedge clk);
        check("t4_s1", a_out.tdata, 8'hBB);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_pending", a_out.tdata, 8'hCC);
        check("t4_rst_ready_comb", a_in.tready, 0);
        @(posedge clk);
        @(negedge clk);
        check("t4_rst_valid", a_out.tvalid, 0);
        check("t4_rst_ready", a_in.tready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_rel_ready", a_in.tready, 1);
        check("t4_rel_valid", a_out.tvalid, 0);
        w = 32'h04030201;
        send_a(w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_new_valid", a_out.tvalid, 1);
            check("t4_new_data", a_out.tdata, 8'(w >> (8 * i)));
        end
        @(negedge clk);
        check("t4_idle", a_out.tvalid, 0);

        // One-slice instance: register-slice behaviour
        @(posedge clk);
        #1;
        b_in.tdata  = 16'h1234;
        b_in.tvalid = 1'b1;
        @(negedge clk);
        check("t6_ready_idle", b_in.tready, 1);
        @(posedge clk);
        #1;
        b_in.tdata = 16'hABCD;
        @(negedge clk);
        check("t6_v0", b_out.tvalid, 1);
        check("t6_d0", b_out.tdata, 16'h1234);
        check("t6_ready_pass", b_in.tready, 1);
        @(posedge clk);
        #1;
        b_in.tvalid = 1'b0;
        @(negedge clk);
        check("t6_v1", b_out.tvalid, 1);
        check("t6_d1", b_out.tdata, 16'hABCD);
        @(posedge clk);
        @(negedge clk);
        check("t6_idle", b_out.tvalid, 0);
        @(posedge clk);
        #1;
        b_in.tdata   = 16'h5A5A;
        b_in.tvalid  = 1'b1;
        b_out.tready = 1'b0;
        @(posedge clk);
        #1;
        b_in.tvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t6_stall_valid", b_out.tvalid, 1);
            check("t6_stall_data", b_out.tdata, 16'h5A5A);
            check("t6_stall_ready", b_in.tready, 0);
        end
        @(posedge clk);
        #1;
        b_out.tready = 1'b1;
        @(negedge clk);
        check("t6_release_ready", b_in.tready, 1);
        @(posedge clk);
        @(negedge clk);
        check("t6_idle2", b_out.tvalid, 0);

        // Random traffic on both instances
        fork
            rand_a(1000);
            rand_b(300);
        join
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        check("a_drain", qa.size(), 0);
        check("b_drain", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
